// File: rtl/generador_verificador_compuertas.sv
// Exhaustive stimulus generator and response checker for the XOR/AND gate lab.
// Walks every WIDTH-bit vector, samples gate responses after SETTLE cycles.
module generador_verificador_compuertas #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1,
    parameter int NXOR   = 2,
    parameter int NAND   = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NXOR-1:0]  rta_xor,
    input  logic [NAND-1:0]  rta_and,
    output logic [WIDTH-1:0] estimulo,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] error_count,
    output logic [NXOR-1:0]  err_xor,
    output logic [NAND-1:0]  err_and,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_estimulo
);

    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t         state, stateNext;
    logic [WCW-1:0] wcnt;
    logic           gx, ga, anyFail, lastVec;
    logic [NXOR-1:0] mx;
    logic [NAND-1:0] ma;

    assign gx      = ^estimulo;
    assign ga      = &estimulo;
    assign mx      = rta_xor ^ {NXOR{gx}};
    assign ma      = rta_and ^ {NAND{ga}};
    assign anyFail = (|mx) | (|ma);
    assign lastVec = (estimulo == {WIDTH{1'b1}});

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE, DONE: if (start) stateNext = WAIT;
            WAIT:  if (wcnt == WCW'(SETTLE - 1)) stateNext = CHECK;
            CHECK: stateNext = lastVec ? DONE : WAIT;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            wcnt                <= '0;
            estimulo            <= '0;
            error_count         <= '0;
            err_xor             <= '0;
            err_and             <= '0;
            first_fail_valid    <= 1'b0;
            first_fail_estimulo <= '0;
        end else begin
            state <= stateNext;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        wcnt                <= '0;
                        estimulo            <= '0;
                        error_count         <= '0;
                        err_xor             <= '0;
                        err_and             <= '0;
                        first_fail_valid    <= 1'b0;
                        first_fail_estimulo <= '0;
                    end
                end
                WAIT: wcnt <= wcnt + 1'b1;
                CHECK: begin
                    err_xor <= err_xor | mx;
                    err_and <= err_and | ma;
                    if (anyFail) begin
                        // Saturate so a long failing run never reads as clean
                        if (error_count != {CNT_W{1'b1}})
                            error_count <= error_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid    <= 1'b1;
                            first_fail_estimulo <= estimulo;
                        end
                    end
                    if (!lastVec) begin
                        estimulo <= estimulo + 1'b1;
                        wcnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (error_count == '0);

endmodule

// File: tb/tb_generador_verificador_compuertas.sv
// Directed bench: fault-injected gate models drive three checker configurations.
// Default, WIDTH=3/SETTLE=3 with WAIT glitches, and CNT_W=2 saturation.
module tb_generador_verificador_compuertas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nApplied = 0;
    int nFail    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nApplied++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- DUT0: defaults ----------------
    logic       rst0, start0;
    logic [1:0] xs0, xinv, as0, ainv;
    logic [1:0] rx0, ra0, est0, ex0, ea0, ffe0;
    logic       busy0, done0, pass0, ffv0;
    logic [7:0] cnt0;

    assign rx0 = ({2{^est0}} & ~xs0) ^ xinv;
    assign ra0 = ({2{&est0}} & ~as0) ^ ainv;

    generador_verificador_compuertas dut0 (
        .clk(clk), .reset(rst0), .start(start0),
        .rta_xor(rx0), .rta_and(ra0), .estimulo(est0),
        .busy(busy0), .done(done0), .pass(pass0),
        .error_count(cnt0), .err_xor(ex0), .err_and(ea0),
        .first_fail_valid(ffv0), .first_fail_estimulo(ffe0)
    );

    // ---------------- DUT1: WIDTH=3, SETTLE=3 ----------------
    logic       rst1, start1, busy1, done1, pass1, ffv1;
    logic [1:0] rx1, ra1, ex1, ea1;
    logic [2:0] est1, ffe1;
    logic [7:0] cnt1;

    generador_verificador_compuertas #(.WIDTH(3), .SETTLE(3)) dut1 (
        .clk(clk), .reset(rst1), .start(start1),
        .rta_xor(rx1), .rta_and(ra1), .estimulo(est1),
        .busy(busy1), .done(done1), .pass(pass1),
        .error_count(cnt1), .err_xor(ex1), .err_and(ea1),
        .first_fail_valid(ffv1), .first_fail_estimulo(ffe1)
    );

    // ---------------- DUT2: CNT_W=2, all gates inverted ----------------
    logic       rst2, start2, busy2, done2, pass2, ffv2;
    logic [1:0] rx2, ra2, est2, ex2, ea2, ffe2, cnt2;

    assign rx2 = ~{2{^est2}};
    assign ra2 = ~{2{&est2}};

    generador_verificador_compuertas #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(rst2), .start(start2),
        .rta_xor(rx2), .rta_and(ra2), .estimulo(est2),
        .busy(busy2), .done(done2), .pass(pass2),
        .error_count(cnt2), .err_xor(ex2), .err_and(ea2),
        .first_fail_valid(ffv2), .first_fail_estimulo(ffe2)
    );

    typedef struct {
        string      nm;
        logic [1:0] xs0, xinv, as0, ainv;
        int         cnt;
        logic [1:0] ex, ea;
        logic       ffv;
        logic [1:0] ffe;
        logic       ps;
    } vec_t;

    vec_t tbl[6];

    task automatic run0(input bit seqChk, input bit glitch, output int lat);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        chk("clr_cnt", cnt0, 0);
        chk("clr_done", done0, 0);
        chk("clr_ffv", ffv0, 0);
        if (seqChk) chk("est_k0", est0, 0);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (glitch) start0 = (k == 3 || k == 4);
            @(posedge clk);
            @(negedge clk);
            if (seqChk && k <= 8)
                chk($sformatf("est_k%0d", k), est0, (k >= 6) ? 3 : k / 2);
            if (seqChk && k == 1) chk("busy_k1", busy0, 1);
            if (done0) begin
                lat = k;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    int lat;

    initial begin
        tbl[0] = '{"clean",     2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 2'd0, 1};
        tbl[1] = '{"x1_sa0",    2'b10, 2'b00, 2'b00, 2'b00, 2, 2'b10, 2'b00, 1, 2'd1, 0};
        tbl[2] = '{"a0_inv",    2'b00, 2'b00, 2'b00, 2'b01, 4, 2'b00, 2'b01, 1, 2'd0, 0};
        tbl[3] = '{"x0inv_a1",  2'b00, 2'b01, 2'b10, 2'b00, 4, 2'b01, 2'b10, 1, 2'd0, 0};
        tbl[4] = '{"a1_sa0",    2'b00, 2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b10, 1, 2'd3, 0};
        tbl[5] = '{"x_both_sa0",2'b11, 2'b00, 2'b00, 2'b00, 2, 2'b11, 2'b00, 1, 2'd1, 0};

        {xs0, xinv, as0, ainv} = '0;
        {start0, start1, start2} = '0;
        rx1 = '0; ra1 = '0;
        {rst0, rst1, rst2} = 3'b111;
        repeat (2) @(negedge clk);
        {rst0, rst1, rst2} = 3'b000;
        @(negedge clk);

        chk("rst_est", est0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_errs", {ex0, ea0}, 0);
        chk("rst_ff", {ffv0, ffe0}, 0);

        for (int i = 0; i < 6; i++) begin
            xs0 = tbl[i].xs0; xinv = tbl[i].xinv;
            as0 = tbl[i].as0; ainv = tbl[i].ainv;
            run0(i == 0, i == 0, lat);
            chk({tbl[i].nm, "_lat"}, lat, 8);
            chk({tbl[i].nm, "_cnt"}, cnt0, tbl[i].cnt);
            chk({tbl[i].nm, "_exor"}, ex0, tbl[i].ex);
            chk({tbl[i].nm, "_eand"}, ea0, tbl[i].ea);
            chk({tbl[i].nm, "_ffv"}, ffv0, tbl[i].ffv);
            chk({tbl[i].nm, "_ffe"}, ffe0, tbl[i].ffe);
            chk({tbl[i].nm, "_pass"}, pass0, tbl[i].ps);
            repeat (2) @(negedge clk);
            chk({tbl[i].nm, "_hold"}, done0, 1);
        end

        // Mid-run reset with errors already accumulated
        {xs0, xinv, as0} = '0;
        ainv = 2'b01;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_cnt", cnt0, 2);
        chk("mid_busy", busy0, 1);
        #1 rst0 = 1'b1;
        #1;
        chk("arst_est", est0, 0);
        chk("arst_cnt", cnt0, 0);
        chk("arst_eand", ea0, 0);
        chk("arst_ffv", ffv0, 0);
        chk("arst_busy", busy0, 0);
        @(negedge clk);
        rst0 = 1'b0;
        ainv = 2'b00;
        run0(0, 0, lat);
        chk("post_lat", lat, 8);
        chk("post_pass", pass0, 1);
        chk("post_cnt", cnt0, 0);

        // DUT1: correct response only during CHECK, garbage during WAIT
        @(negedge clk);
        start1 = 1'b1;
        rx1 = 2'b11; ra1 = 2'b11;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k % 4 == 0) begin
                rx1 = {2{^est1}};
                ra1 = {2{&est1}};
            end else begin
                rx1 = ~{2{^est1}};
                ra1 = ~{2{&est1}};
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 12) chk("w3_est_k12", est1, 3);
            if (k == 31) chk("w3_done_k31", done1, 0);
            if (k == 32) chk("w3_done_k32", done1, 1);
        end
        chk("w3_est_end", est1, 7);
        chk("w3_pass", pass1, 1);
        chk("w3_cnt", cnt1, 0);

        // DUT2: four failures into a 2-bit counter
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2) begin
                lat = k;
                break;
            end
        end
        chk("sat_lat", lat, 8);
        chk("sat_cnt", cnt2, 3);
        chk("sat_errs", {ex2, ea2}, 4'b1111);
        chk("sat_ffe", ffe2, 0);
        chk("sat_pass", pass2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule
